rx_status_event_monitor: RTL

//  Downstream consumer of the encoded PIPE RxStatus[2:0] code. Keeps one saturating

---
 rtl/rx_status_event_monitor.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/rx_status_event_monitor.sv
`default_nettype none
// ============================================================================
// Module   : rx_status_event_monitor
// Purpose  : Consumes the encoded PIPE RxStatus[2:0] code. Keeps one
//            saturating event counter per code, a sticky "seen" flag per
//            non-zero code, and a windowed error-burst detector that raises
//            a link-quality alarm.
// Ports    : clk        - clock, all logic on rising edge
//            rst_n      - asynchronous reset, active low
//            rx_status  - PIPE status code (0 OK .. 7 disparity error)
//            rx_valid   - rx_status is valid this cycle
//            clr        - synchronous clear of counters, sticky, FSM, rd_count
//            alarm_clr  - acknowledge / clear alarm (only acts in ALARM)
//            rd_sel     - counter select for readback
//            rd_count   - registered count of code rd_sel (1-cycle latency)
//            sticky     - bit k set once code k seen; bit 0 always 0
//            alarm      - error-burst alarm, high while FSM is in ALARM
// Revision : 1.0 - initial release
// ============================================================================
module rx_status_event_monitor #(
    parameter int CNT_W      = 16,
    parameter int WINDOW     = 1024,
    parameter int ERR_THRESH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       rx_status,
    input  logic             rx_valid,
    input  logic             clr,
    input  logic             alarm_clr,
    input  logic [2:0]       rd_sel,
    output logic [CNT_W-1:0] rd_count,
    output logic [7:0]       sticky,
    output logic             alarm
);

    localparam int WIN_W = $clog2(WINDOW);
    localparam int ERR_W = $clog2(ERR_THRESH + 1);

    localparam logic [WIN_W-1:0] C_WIN_LOAD = WIN_W'(WINDOW - 1);
    localparam logic [ERR_W:0]   C_THRESH   = (ERR_W + 1)'(ERR_THRESH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WIN   = 2'd1;
    localparam logic [1:0] S_ALARM = 2'd2;

    // One-hot event decode. The ternary keeps an X on rx_status from
    // reaching any state while rx_valid is low.
    logic [7:0] w_ev;
    logic       w_err;

    assign w_ev  = rx_valid ? (8'b1 << rx_status) : 8'b0;
    assign w_err = |w_ev[7:4];

    // ------------------------------------------------------------------
    // Per-code saturating counters and readback
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_cnt [8];
    logic [7:1]       r_sticky;
    logic [CNT_W-1:0] r_rd_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 8; k++) r_cnt[k] <= '0;
        end else if (clr) begin
            for (int k = 0; k < 8; k++) r_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (w_ev[k] && (r_cnt[k] != {CNT_W{1'b1}}))
                    r_cnt[k] <= r_cnt[k] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_sticky <= '0;
        else if (clr)
            r_sticky <= '0;
        else
            r_sticky <= r_sticky | w_ev[7:1];
    end

    // Reads the pre-increment value: r_cnt is sampled at the same edge
    // that applies this cycle's event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_rd_count <= '0;
        else if (clr)
            r_rd_count <= '0;
        else
            r_rd_count <= r_cnt[rd_sel];
    end

    // ------------------------------------------------------------------
    // Error-burst detector
    // ------------------------------------------------------------------
    logic [1:0]       r_state,  w_state_nxt;
    logic [WIN_W-1:0] r_win,    w_win_nxt;
    logic [ERR_W-1:0] r_err,    w_err_nxt;
    logic [ERR_W:0]   w_err_inc;
    logic             r_alarm;

    assign w_err_inc = {1'b0, r_err} + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_win_nxt   = r_win;
        w_err_nxt   = r_err;
        case (r_state)
            S_IDLE: begin
                if (w_err) begin
                    w_err_nxt   = ERR_W'(1);
                    w_win_nxt   = C_WIN_LOAD;
                    w_state_nxt = (ERR_THRESH == 1) ? S_ALARM : S_WIN;
                end
            end
            S_WIN: begin
                // Threshold wins over expiry; an error on the expiry cycle
                // that does not reach threshold is discarded with the window.
                if (w_err && (w_err_inc >= C_THRESH)) begin
                    w_state_nxt = S_ALARM;
                end else if (r_win == '0) begin
                    w_state_nxt = S_IDLE;
                    w_err_nxt   = '0;
                end else begin
                    w_win_nxt = r_win - 1'b1;
                    if (w_err)
                        w_err_nxt = w_err_inc[ERR_W-1:0];
                end
            end
            S_ALARM: begin
                if (alarm_clr) begin
                    w_state_nxt = S_IDLE;
                    w_err_nxt   = '0;
                    w_win_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_err_nxt   = '0;
                w_win_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_win   <= '0;
            r_err   <= '0;
            r_alarm <= 1'b0;
        end else if (clr) begin
            r_state <= S_IDLE;
            r_win   <= '0;
            r_err   <= '0;
            r_alarm <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_win   <= w_win_nxt;
            r_err   <= w_err_nxt;
            r_alarm <= (w_state_nxt == S_ALARM);
        end
    end

    assign rd_count = r_rd_count;
    assign sticky   = {r_sticky, 1'b0};
    assign alarm    = r_alarm;

endmodule
`default_nettype wire
